// File: rtl/sd_spi_ctrl.sv
// APB-programmable SPI master for SD cards (mode 0, MSB-first, 1..32-bit frames).
// Each SCLK half-period lasts div+1 cycles. A transfer is started by a LEN write.
module sd_spi_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd62
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  apb_PADDR,
  input  logic        apb_PSEL,
  input  logic        apb_PENABLE,
  input  logic        apb_PWRITE,
  input  logic [31:0] apb_PWDATA,
  output logic [31:0] apb_PRDATA,
  output logic        apb_PREADY,
  output logic        sd_sclk,
  output logic        sd_mosi,
  input  logic        sd_miso,
  output logic        sd_cs_n,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  logic [1:0]  state;
  logic        cs;
  logic        irq_en;
  logic [7:0]  div;
  logic [7:0]  cnt;
  logic [31:0] txdata;
  logic [31:0] rx;
  logic [5:0]  len;
  logic        done;
  logic        busy;

  logic        wr;
  logic        rd;
  logic        wr_ctrl;
  logic        wr_tx;
  logic        wr_len;
  logic        rd_rx;
  logic        len_ok;
  logic        start;
  logic        done_set;
  logic [4:0]  start_idx;
  logic [4:0]  next_idx;

  assign wr      = apb_PSEL & apb_PENABLE & apb_PWRITE;
  assign rd      = apb_PSEL & apb_PENABLE & ~apb_PWRITE;
  assign wr_ctrl = wr && (apb_PADDR == 8'h00);
  assign wr_tx   = wr && (apb_PADDR == 8'h04);
  assign wr_len  = wr && (apb_PADDR == 8'h08);
  assign rd_rx   = rd && (apb_PADDR == 8'h0C);

  assign busy     = (state != S_IDLE);
  assign len_ok   = (apb_PWDATA != 32'd0) && (apb_PWDATA <= 32'd32);
  assign start    = wr_len && len_ok && !busy;
  assign done_set = (state == S_HIGH) && (cnt == 8'd0) && (len == 6'd1);

  // len counts bits still to go; a 5-bit wrap maps a count of 32 onto bit 31
  assign start_idx = apb_PWDATA[4:0] - 5'd1;
  assign next_idx  = len[4:0] - 5'd2;

  assign apb_PREADY = 1'b1;
  assign sd_cs_n    = ~cs;
  assign irq        = done & irq_en;

  always_comb begin
    apb_PRDATA = 32'hFFFF_FFFF;
    case (apb_PADDR)
      8'h00:   apb_PRDATA = {16'd0, div, 6'd0, irq_en, cs};
      8'h04:   apb_PRDATA = txdata;
      8'h08:   apb_PRDATA = 32'd0;
      8'h0C:   apb_PRDATA = rx;
      8'h10:   apb_PRDATA = {30'd0, done, busy};
      default: apb_PRDATA = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cs      <= 1'b0;
      irq_en  <= 1'b0;
      div     <= DIV_RESET;
      cnt     <= 8'd0;
      txdata  <= 32'd0;
      rx      <= 32'd0;
      len     <= 6'd0;
      done    <= 1'b0;
      sd_sclk <= 1'b0;
      sd_mosi <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        cs     <= apb_PWDATA[0];
        irq_en <= apb_PWDATA[1];
        if (!busy) div <= apb_PWDATA[15:8];
      end
      if (wr_tx && !busy) txdata <= apb_PWDATA;

      // set beats clear when both land in the same cycle
      if (done_set)           done <= 1'b1;
      else if (start || rd_rx) done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOW;
            len     <= apb_PWDATA[5:0];
            rx      <= 32'd0;
            cnt     <= div;
            sd_sclk <= 1'b0;
            sd_mosi <= txdata[start_idx];
          end
        end
        S_LOW: begin
          if (cnt == 8'd0) begin
            state   <= S_HIGH;
            cnt     <= div;
            sd_sclk <= 1'b1;
            rx      <= {rx[30:0], sd_miso};
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HIGH: begin
          if (cnt == 8'd0) begin
            cnt     <= div;
            sd_sclk <= 1'b0;
            if (len == 6'd1) begin
              state   <= S_IDLE;
              len     <= 6'd0;
              sd_mosi <= 1'b1;
            end else begin
              state   <= S_LOW;
              len     <= len - 6'd1;
              sd_mosi <= txdata[next_idx];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          sd_sclk <= 1'b0;
          sd_mosi <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Scoreboarded bench for sd_spi_ctrl: stimulus queues expectations, a negedge
// monitor compares APB reads, MOSI bits, SCLK periods and transfer durations.
module tb_sd_spi_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        sd_sclk;
  logic        sd_mosi;
  logic        sd_miso;
  logic        sd_cs_n;
  logic        irq;
  logic        loop;
  logic        miso_val;

  assign sd_miso = loop ? sd_mosi : miso_val;

  sd_spi_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .apb_PADDR  (paddr),
    .apb_PSEL   (psel),
    .apb_PENABLE(penable),
    .apb_PWRITE (pwrite),
    .apb_PWDATA (pwdata),
    .apb_PRDATA (prdata),
    .apb_PREADY (pready),
    .sd_sclk    (sd_sclk),
    .sd_mosi    (sd_mosi),
    .sd_miso    (sd_miso),
    .sd_cs_n    (sd_cs_n),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  string       rd_name[$];
  logic [31:0] rd_exp[$];
  logic        mosi_q[$];
  int          per_q[$];
  int          dur_q[$];
  logic        irq_q[$];
  string       obs_name[$];
  logic [31:0] obs_act[$];
  logic [31:0] obs_exp[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // stimulus-side observations are handed to the monitor for comparison
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    obs_name.push_back(nm);
    obs_act.push_back(act);
    obs_exp.push_back(exp);
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    rd_name.push_back(nm);
    rd_exp.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (dut.done) break;
      @(posedge clk); #1;
    end
    chk("done_within_budget", {31'd0, dut.done}, 32'd1);
  endtask

  // monitor
  initial begin
    int   cyc;
    int   t_start;
    int   last_rise;
    int   cur_per;
    logic first_rise;
    logic prev_sclk;
    logic prev_busy;
    logic prev_done;
    cyc = 0; t_start = 0; last_rise = 0; cur_per = 0; first_rise = 1'b1;
    prev_sclk = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (psel && penable && !pwrite) begin
          if (rd_exp.size() == 0) cmp("unexpected_read", 32'd1, 32'd0);
          else cmp(rd_name.pop_front(), prdata, rd_exp.pop_front());
        end
        if (dut.busy && !prev_busy) begin
          t_start    = cyc;
          first_rise = 1'b1;
          cur_per    = (per_q.size() != 0) ? per_q.pop_front() : 0;
        end
        if (sd_sclk && !prev_sclk) begin
          if (mosi_q.size() != 0) cmp("mosi_bit", {31'd0, sd_mosi}, {31'd0, mosi_q.pop_front()});
          if (!first_rise && cur_per != 0) cmp("sclk_period", cyc - last_rise, cur_per);
          first_rise = 1'b0;
          last_rise  = cyc;
        end
        if (dut.done && !prev_done) begin
          if (dur_q.size() == 0) cmp("unexpected_done", 32'd1, 32'd0);
          else begin
            cmp("duration", cyc - t_start, dur_q.pop_front());
            cmp("irq_at_done", {31'd0, irq}, {31'd0, irq_q.pop_front()});
          end
        end
      end
      while (obs_exp.size() != 0) cmp(obs_name.pop_front(), obs_act.pop_front(), obs_exp.pop_front());
      prev_sclk = sd_sclk;
      prev_busy = dut.busy;
      prev_done = dut.done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a5_bits;
    logic [31:0] beef;
    a5_bits = 8'b1010_0101;
    beef    = 32'hDEAD_BEEF;
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 32'd0; loop = 1'b1; miso_val = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_pready", {31'd0, pready}, 32'd1);
    chk("rst_sclk",   {31'd0, sd_sclk}, 32'd0);
    chk("rst_mosi",   {31'd0, sd_mosi}, 32'd1);
    chk("rst_cs_n",   {31'd0, sd_cs_n}, 32'd1);
    chk("rst_irq",    {31'd0, irq}, 32'd0);
    apb_rd(8'h00, 32'h0000_3E00, "rst_ctrl");
    apb_rd(8'h04, 32'h0000_0000, "rst_txdata");
    apb_rd(8'h08, 32'h0000_0000, "rst_len");
    apb_rd(8'h0C, 32'h0000_0000, "rst_rxdata");
    apb_rd(8'h10, 32'h0000_0000, "rst_status");
    apb_rd(8'h14, 32'hFFFF_FFFF, "unmapped");

    // 8-bit loopback, div=0
    apb_wr(8'h00, 32'h0000_0001);
    chk("cs_n_low", {31'd0, sd_cs_n}, 32'd0);
    apb_wr(8'h04, 32'h0000_00A5);
    for (int i = 7; i >= 0; i--) mosi_q.push_back(a5_bits[i]);
    per_q.push_back(2); dur_q.push_back(16); irq_q.push_back(1'b0);
    loop = 1'b1;
    apb_wr(8'h08, 32'd8);
    wait_done(100);
    apb_rd(8'h10, 32'h0000_0002, "a5_status_done");
    apb_rd(8'h0C, 32'h0000_00A5, "a5_rxdata");
    apb_rd(8'h10, 32'h0000_0000, "a5_status_cleared");

    // 32-bit loopback, div=2, writes while busy
    apb_wr(8'h00, 32'h0000_0201);
    apb_wr(8'h04, 32'hDEAD_BEEF);
    for (int i = 31; i >= 0; i--) mosi_q.push_back(beef[i]);
    per_q.push_back(6); dur_q.push_back(192); irq_q.push_back(1'b0);
    apb_wr(8'h08, 32'd32);
    repeat (5) @(posedge clk);
    #1;
    apb_wr(8'h08, 32'd5);
    apb_wr(8'h04, 32'h0000_0000);
    apb_wr(8'h00, 32'h0000_0001);
    apb_rd(8'h00, 32'h0000_0201, "busy_ctrl_div_kept");
    apb_rd(8'h04, 32'hDEAD_BEEF, "busy_txdata_kept");
    apb_rd(8'h10, 32'h0000_0001, "busy_status");
    wait_done(400);
    apb_rd(8'h0C, 32'hDEAD_BEEF, "beef_rxdata");

    // single bit with irq, MISO held high
    apb_wr(8'h00, 32'h0000_0103);
    loop = 1'b0; miso_val = 1'b1;
    mosi_q.push_back(1'b1);
    dur_q.push_back(4); irq_q.push_back(1'b1);
    apb_wr(8'h08, 32'd1);
    wait_done(50);
    chk("irq_high", {31'd0, irq}, 32'd1);
    apb_rd(8'h0C, 32'h0000_0001, "bit1_rxdata");
    chk("irq_dropped", {31'd0, irq}, 32'd0);

    // reset during bit 5
    apb_wr(8'h00, 32'h0000_0001);
    apb_wr(8'h04, 32'h0000_00A5);
    loop = 1'b1;
    per_q.push_back(2);
    apb_wr(8'h08, 32'd8);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_sclk", {31'd0, sd_sclk}, 32'd0);
    chk("mid_rst_mosi", {31'd0, sd_mosi}, 32'd1);
    chk("mid_rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
    chk("mid_rst_busy", {31'd0, dut.busy}, 32'd0);
    apb_rd(8'h00, 32'h0000_3E00, "mid_rst_ctrl");
    apb_wr(8'h08, 32'd0);
    apb_rd(8'h10, 32'h0000_0000, "len0_no_start");
    apb_wr(8'h08, 32'd33);
    apb_rd(8'h10, 32'h0000_0000, "len33_no_start");
    apb_rd(8'h0C, 32'h0000_0000, "mid_rst_rxdata");

    chk("mosi_queue_drained", mosi_q.size(), 32'd0);
    chk("dur_queue_drained",  dur_q.size(), 32'd0);
    chk("read_queue_drained", rd_exp.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
